rs_station_param: RTL and testbench

- Parametrised reservation station for the Tomasulo core, one instance per functional-unit class (add/branch/ld-st, mul/div).
- Accepts dispatched instructions whose operands are either values or ROB tags.
- Snoops the common data bus (CDB) to capture pending operands.
- Issues the oldest fully-ready entry to its execution unit over a valid/ready handshake.

---
 rtl/rs_station_param.sv | 166 ++++++++++++++++
 tb/tb_rs_station_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station_param.sv
// Reservation station: holds dispatched ops, snoops the CDB for pending operands,
// and issues the oldest fully-ready entry over a valid/ready handshake.
module rs_entry #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4,
  parameter int RD_W   = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr,
  input  logic              clr,
  input  logic              dec,
  input  logic [CNT_W-1:0]  wr_age,
  input  logic [FUNC_W-1:0] wr_func,
  input  logic [TAG_W-1:0]  wr_rob,
  input  logic [RD_W-1:0]   wr_rd,
  input  logic              wr_rdy1,
  input  logic [DATA_W-1:0] wr_val1,
  input  logic [TAG_W-1:0]  wr_tag1,
  input  logic              wr_rdy2,
  input  logic [DATA_W-1:0] wr_val2,
  input  logic [TAG_W-1:0]  wr_tag2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              valid,
  output logic              elig,
  output logic [FUNC_W-1:0] func,
  output logic [TAG_W-1:0]  rob,
  output logic [RD_W-1:0]   rd,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [CNT_W-1:0]  age
);
  logic             rdy1, rdy2;
  logic [TAG_W-1:0] tag1, tag2;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0; func <= '0; rob <= '0; rd <= '0; age <= '0;
      rdy1 <= 1'b0; val1 <= '0; tag1 <= '0;
      rdy2 <= 1'b0; val2 <= '0; tag2 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (wr) begin
      valid <= 1'b1; func <= wr_func; rob <= wr_rob; rd <= wr_rd; age <= wr_age;
      rdy1 <= wr_rdy1; val1 <= wr_val1; tag1 <= wr_tag1;
      rdy2 <= wr_rdy2; val2 <= wr_val2; tag2 <= wr_tag2;
    end else if (valid) begin
      if (clr) valid <= 1'b0;
      else begin
        if (dec) age <= age - CNT_W'(1);
        if (cdb_valid && !rdy1 && tag1 == cdb_tag) begin rdy1 <= 1'b1; val1 <= cdb_data; end
        if (cdb_valid && !rdy2 && tag2 == cdb_tag) begin rdy2 <= 1'b1; val2 <= cdb_data; end
      end
    end
  end

  assign elig = valid & rdy1 & rdy2;
endmodule

module rs_station_param #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4,
  parameter int RD_W   = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [FUNC_W-1:0] disp_func,
  input  logic [TAG_W-1:0]  disp_rob,
  input  logic [RD_W-1:0]   disp_rd,
  input  logic              disp_op1_rdy,
  input  logic [DATA_W-1:0] disp_op1_val,
  input  logic [TAG_W-1:0]  disp_op1_tag,
  input  logic              disp_op2_rdy,
  input  logic [DATA_W-1:0] disp_op2_val,
  input  logic [TAG_W-1:0]  disp_op2_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [FUNC_W-1:0] iss_func,
  output logic [DATA_W-1:0] iss_op1,
  output logic [DATA_W-1:0] iss_op2,
  output logic [TAG_W-1:0]  iss_rob,
  output logic [RD_W-1:0]   iss_rd,
  output logic [CNT_W-1:0]  count
);
  logic [DEPTH-1:0]             e_valid, e_elig, sel_oh, free_oh;
  logic [DEPTH-1:0][FUNC_W-1:0] e_func;
  logic [DEPTH-1:0][TAG_W-1:0]  e_rob;
  logic [DEPTH-1:0][RD_W-1:0]   e_rd;
  logic [DEPTH-1:0][DATA_W-1:0] e_val1, e_val2;
  logic [DEPTH-1:0][CNT_W-1:0]  e_age;
  logic [CNT_W-1:0]             sel_age, new_age;
  logic                         disp_fire, iss_fire, byp1, byp2, found, taken;

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_fire   = iss_valid && iss_ready && !flush;
  assign new_age    = iss_fire ? count - CNT_W'(1) : count;

  // An operand broadcast in the dispatch cycle would otherwise be missed forever.
  assign byp1 = cdb_valid && !disp_op1_rdy && (disp_op1_tag == cdb_tag);
  assign byp2 = cdb_valid && !disp_op2_rdy && (disp_op2_tag == cdb_tag);

  always_comb begin
    found   = 1'b0;
    sel_age = '0;
    sel_oh  = '0;
    free_oh = '0;
    taken   = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (e_elig[i] && (!found || e_age[i] < sel_age)) begin
        found   = 1'b1;
        sel_age = e_age[i];
      end
    for (int i = 0; i < DEPTH; i++) begin
      if (e_elig[i] && e_age[i] == sel_age) sel_oh[i] = 1'b1;
      if (!e_valid[i] && !taken) begin free_oh[i] = 1'b1; taken = 1'b1; end
    end
  end

  always_comb begin
    iss_func = '0; iss_op1 = '0; iss_op2 = '0; iss_rob = '0; iss_rd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) begin
        iss_func = e_func[i]; iss_op1 = e_val1[i]; iss_op2 = e_val2[i];
        iss_rob  = e_rob[i];  iss_rd  = e_rd[i];
      end
  end
  assign iss_valid = found;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .FUNC_W(FUNC_W), .RD_W(RD_W), .CNT_W(CNT_W)) u_ent (
      .clk1(clk1), .rst_n(rst_n), .flush(flush),
      .wr(disp_fire && free_oh[g]),
      .clr(iss_fire && sel_oh[g]),
      .dec(iss_fire && (e_age[g] > sel_age)),
      .wr_age(new_age), .wr_func(disp_func), .wr_rob(disp_rob), .wr_rd(disp_rd),
      .wr_rdy1(disp_op1_rdy | byp1), .wr_val1(byp1 ? cdb_data : disp_op1_val), .wr_tag1(disp_op1_tag),
      .wr_rdy2(disp_op2_rdy | byp2), .wr_val2(byp2 ? cdb_data : disp_op2_val), .wr_tag2(disp_op2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid(e_valid[g]), .elig(e_elig[g]), .func(e_func[g]), .rob(e_rob[g]), .rd(e_rd[g]),
      .val1(e_val1[g]), .val2(e_val2[g]), .age(e_age[g])
    );
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)                       count <= '0;
    else if (flush)                   count <= '0;
    else if (disp_fire && !iss_fire)  count <= count + CNT_W'(1);
    else if (iss_fire && !disp_fire)  count <= count - CNT_W'(1);
  end
endmodule

// File: tb/tb_rs_station_param.sv
// Bench for rs_station_param: directed scenarios with literal checks plus random
// traffic compared every cycle against an age-ordered queue model.
module tb_rs_station_param;
  localparam int DEPTH = 4;

  logic        clk1 = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        disp_valid = 1'b0, disp_ready;
  logic [3:0]  disp_func = '0, disp_rd = '0;
  logic [2:0]  disp_rob = '0, disp_op1_tag = '0, disp_op2_tag = '0, cdb_tag = '0;
  logic        disp_op1_rdy = 1'b0, disp_op2_rdy = 1'b0, cdb_valid = 1'b0;
  logic [15:0] disp_op1_val = '0, disp_op2_val = '0, cdb_data = '0;
  logic        iss_valid, iss_ready = 1'b0;
  logic [3:0]  iss_func, iss_rd;
  logic [15:0] iss_op1, iss_op2;
  logic [2:0]  iss_rob;
  logic [4:0]  count;

  int total = 0, bad = 0;

  always #5 clk1 = ~clk1;

  rs_station_param dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_func(disp_func),
    .disp_rob(disp_rob), .disp_rd(disp_rd),
    .disp_op1_rdy(disp_op1_rdy), .disp_op1_val(disp_op1_val), .disp_op1_tag(disp_op1_tag),
    .disp_op2_rdy(disp_op2_rdy), .disp_op2_val(disp_op2_val), .disp_op2_tag(disp_op2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_rob(iss_rob), .iss_rd(iss_rd),
    .count(count)
  );

  // Model: queue ordered oldest-first, so an entry's age is its queue position.
  typedef struct {
    logic [3:0] func; logic [2:0] rob; logic [3:0] rd;
    bit r1; logic [15:0] v1; logic [2:0] t1;
    bit r2; logic [15:0] v2; logic [2:0] t2;
  } ment_t;
  ment_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_elig();
    for (int i = 0; i < q.size(); i++) if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  task automatic model_step();
    ment_t e;
    int k;
    bit dr;
    dr = q.size() < DEPTH;
    if (flush) begin q.delete(); return; end
    k = first_elig();
    if (k >= 0 && iss_ready) q.delete(k);
    if (cdb_valid)
      foreach (q[i]) begin
        if (!q[i].r1 && q[i].t1 == cdb_tag) begin q[i].r1 = 1; q[i].v1 = cdb_data; end
        if (!q[i].r2 && q[i].t2 == cdb_tag) begin q[i].r2 = 1; q[i].v2 = cdb_data; end
      end
    if (disp_valid && dr) begin
      e.func = disp_func; e.rob = disp_rob; e.rd = disp_rd;
      e.r1 = disp_op1_rdy; e.v1 = disp_op1_val; e.t1 = disp_op1_tag;
      e.r2 = disp_op2_rdy; e.v2 = disp_op2_val; e.t2 = disp_op2_tag;
      if (!e.r1 && cdb_valid && e.t1 == cdb_tag) begin e.r1 = 1; e.v1 = cdb_data; end
      if (!e.r2 && cdb_valid && e.t2 == cdb_tag) begin e.r2 = 1; e.v2 = cdb_data; end
      q.push_back(e);
    end
  endtask

  task automatic check_model();
    int k, seen, nv;
    k = first_elig();
    chk("count", 32'(count), 32'(q.size()));
    chk("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
    chk("iss_valid", 32'(iss_valid), 32'(k >= 0));
    if (k >= 0) begin
      chk("iss_func", 32'(iss_func), 32'(q[k].func));
      chk("iss_op1", 32'(iss_op1), 32'(q[k].v1));
      chk("iss_op2", 32'(iss_op2), 32'(q[k].v2));
      chk("iss_rob", 32'(iss_rob), 32'(q[k].rob));
      chk("iss_rd", 32'(iss_rd), 32'(q[k].rd));
    end
    seen = 0; nv = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut.e_valid[i]) begin nv++; seen |= (1 << dut.e_age[i]); end
    chk("age_perm", 32'(seen), 32'((1 << q.size()) - 1));
    chk("valid_cnt", 32'(nv), 32'(q.size()));
  endtask

  task automatic cycle();
    @(posedge clk1); model_step();
    @(negedge clk1); check_model();
  endtask

  task automatic set_disp(input bit v, input logic [3:0] f, input logic [2:0] rob, input logic [3:0] rd,
                          input bit r1, input logic [15:0] v1, input logic [2:0] t1,
                          input bit r2, input logic [15:0] v2, input logic [2:0] t2);
    disp_valid = v; disp_func = f; disp_rob = rob; disp_rd = rd;
    disp_op1_rdy = r1; disp_op1_val = v1; disp_op1_tag = t1;
    disp_op2_rdy = r2; disp_op2_val = v2; disp_op2_tag = t2;
  endtask

  function automatic int age_of_rob(input logic [2:0] rob);
    for (int i = 0; i < DEPTH; i++)
      if (dut.e_valid[i] && dut.e_rob[i] == rob) return int'(dut.e_age[i]);
    return -1;
  endfunction

  initial begin
    @(negedge clk1);
    chk("rst_count", 32'(count), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_op1", 32'(iss_op1), 0);
    rst_n = 1'b1;

    // Ready-at-dispatch goes straight through.
    set_disp(1, 4'h0, 3'd1, 4'd1, 1, 16'd5, 3'd0, 1, 16'd7, 3'd0);
    iss_ready = 1'b1;
    cycle();
    chk("t1_count", 32'(count), 1);
    chk("t1_valid", 32'(iss_valid), 1);
    chk("t1_op1", 32'(iss_op1), 5);
    chk("t1_op2", 32'(iss_op2), 7);
    chk("t1_rob", 32'(iss_rob), 1);
    disp_valid = 1'b0;
    cycle();
    chk("t1_count_after", 32'(count), 0);

    // CDB wakeup.
    set_disp(1, 4'h2, 3'd2, 4'd3, 0, 16'd0, 3'd3, 1, 16'd1, 3'd0);
    cycle();
    chk("t2_wait", 32'(iss_valid), 0);
    disp_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h00AA;
    cycle();
    cdb_valid = 1'b0;
    chk("t2_valid", 32'(iss_valid), 1);
    chk("t2_op1", 32'(iss_op1), 16'h00AA);
    cycle();

    // Fill, drop fifth, single issue.
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(1, 4'h1, 3'(4 + k), 4'(k), 1, 16'(10 + k), 3'd0, 1, 16'(20 + k), 3'd0);
      cycle();
    end
    chk("t3_full_count", 32'(count), 4);
    chk("t3_full_ready", 32'(disp_ready), 0);
    chk("t3_oldest", 32'(iss_rob), 4);
    set_disp(1, 4'h1, 3'd0, 4'd9, 1, 16'd99, 3'd0, 1, 16'd99, 3'd0);
    cycle();
    chk("t3_drop", 32'(count), 4);
    disp_valid = 1'b0; iss_ready = 1'b1;
    cycle();
    chk("t3_count3", 32'(count), 3);
    chk("t3_ready", 32'(disp_ready), 1);
    chk("t3_next", 32'(iss_rob), 5);
    repeat (3) cycle();

    // Younger ready entry bypasses an older waiting one.
    iss_ready = 1'b0;
    set_disp(1, 4'h3, 3'd1, 4'd1, 0, 16'd0, 3'd5, 1, 16'd9, 3'd0);
    cycle();
    set_disp(1, 4'h4, 3'd2, 4'd2, 1, 16'd8, 3'd0, 1, 16'd9, 3'd0);
    cycle();
    disp_valid = 1'b0;
    chk("t4_b_first", 32'(iss_rob), 2);
    iss_ready = 1'b1;
    cycle();
    chk("t4_count", 32'(count), 1);
    chk("t4_a_waits", 32'(iss_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0033;
    cycle();
    cdb_valid = 1'b0;
    chk("t4_a_rob", 32'(iss_rob), 1);
    chk("t4_a_op1", 32'(iss_op1), 16'h0033);
    chk("t4_a_age", 32'(age_of_rob(3'd1)), 0);
    cycle();

    // Same-cycle dispatch and issue keeps count; full station ignores dispatch.
    iss_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_disp(1, 4'h5, 3'(k), 4'(k), 1, 16'(k), 3'd0, 1, 16'(k), 3'd0);
      cycle();
    end
    set_disp(1, 4'h6, 3'd6, 4'd6, 1, 16'd6, 3'd0, 1, 16'd6, 3'd0);
    iss_ready = 1'b1;
    cycle();
    chk("t5_count", 32'(count), 3);
    chk("t5_new_age", 32'(age_of_rob(3'd6)), 2);
    iss_ready = 1'b0;
    set_disp(1, 4'h7, 3'd7, 4'd7, 1, 16'd7, 3'd0, 1, 16'd7, 3'd0);
    cycle();
    chk("t5_full", 32'(count), 4);
    set_disp(1, 4'h8, 3'd0, 4'd0, 1, 16'd0, 3'd0, 1, 16'd0, 3'd0);
    iss_ready = 1'b1;
    cycle();
    chk("t5_no_credit", 32'(count), 3);

    // Flush beats dispatch, issue and CDB.
    iss_ready = 1'b0;
    set_disp(1, 4'h9, 3'd4, 4'd4, 0, 16'd0, 3'd2, 1, 16'd1, 3'd0);
    cycle();
    cdb_valid = 1'b1; cdb_tag = 3'd2; flush = 1'b1; iss_ready = 1'b1;
    cycle();
    chk("t6_flush_count", 32'(count), 0);
    chk("t6_flush_valid", 32'(iss_valid), 0);
    flush = 1'b0; cdb_valid = 1'b0;

    // Async reset in the middle of a stalled handshake.
    iss_ready = 1'b0;
    set_disp(1, 4'hA, 3'd3, 4'd3, 1, 16'd3, 3'd0, 1, 16'd4, 3'd0);
    cycle();
    disp_valid = 1'b0;
    chk("t7_pending", 32'(iss_valid), 1);
    iss_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_count", 32'(count), 0);
    chk("t7_rst_valid", 32'(iss_valid), 0);
    chk("t7_rst_ready", 32'(disp_ready), 1);
    chk("t7_rst_op1", 32'(iss_op1), 0);
    q.delete();
    @(negedge clk1);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      set_disp(($urandom_range(0, 9) < 6), 4'($urandom), 3'($urandom), 4'($urandom),
               $urandom_range(0, 1) == 1, 16'($urandom), 3'($urandom),
               $urandom_range(0, 1) == 1, 16'($urandom), 3'($urandom));
      cdb_valid = ($urandom_range(0, 9) < 4);
      cdb_tag   = 3'($urandom);
      cdb_data  = 16'($urandom);
      iss_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
